// File: rtl/apb_master_ctrl_if.sv
// rtl/apb_master_ctrl_if.sv - request/response and APB bus bundle for apb_master_ctrl
interface apb_master_ctrl_if #(
  parameter int ADDR_SIZE = 32,
  parameter int MEM_WIDTH = 32,
  parameter int PROT_SIZE = 3
);
  localparam int STRB_SIZE = MEM_WIDTH / 8;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [MEM_WIDTH-1:0] req_wdata;
  logic [STRB_SIZE-1:0] req_strb;
  logic [PROT_SIZE-1:0] req_prot;

  logic                 rsp_valid;
  logic [MEM_WIDTH-1:0] rsp_rdata;
  logic                 rsp_err;
  logic                 rsp_timeout;

  logic                 PSELX;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDR_SIZE-1:0] PADDR;
  logic [MEM_WIDTH-1:0] PWDATA;
  logic [STRB_SIZE-1:0] PSTRB;
  logic [PROT_SIZE-1:0] PPROT;
  logic                 PREADY;
  logic                 PSLVERR;
  logic [MEM_WIDTH-1:0] PRDATA;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  PREADY, PSLVERR, PRDATA,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSELX, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output PREADY, PSLVERR, PRDATA,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSELX, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// rtl/apb_master_ctrl.sv - single-outstanding APB master with bounded-wait timeout
module apb_master_ctrl #(
  parameter int ADDR_SIZE      = 32,
  parameter int MEM_WIDTH      = 32,
  parameter int PROT_SIZE      = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic               PCLK,
  input logic               PRESET,
  apb_master_ctrl_if.master bus
);
  localparam int STRB_SIZE = MEM_WIDTH / 8;
  localparam bit TO_EN     = (TIMEOUT_CYCLES > 0);
  localparam int CNT_W     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pwrite_q, pwrite_d;
  logic [ADDR_SIZE-1:0] paddr_q, paddr_d;
  logic [MEM_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [STRB_SIZE-1:0] pstrb_q, pstrb_d;
  logic [PROT_SIZE-1:0] pprot_q, pprot_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic [MEM_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic req_ready, accept, complete, timeout;

  assign req_ready = (state_q == IDLE) | ((state_q == ACCESS) & bus.PREADY);
  assign accept    = bus.req_valid & req_ready;
  assign complete  = (state_q == ACCESS) & bus.PREADY;
  assign timeout   = TO_EN & (state_q == ACCESS) & ~bus.PREADY & (cnt_q == CNT_LAST);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      pprot_q       <= pprot_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (complete)     state_d = accept ? SETUP : IDLE;
        else if (timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Attributes only move on accept; reads never expose stale write data or strobes.
  always_comb begin
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    pprot_d       = pprot_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = complete | timeout;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    if (accept) begin
      pwrite_d = bus.req_write;
      paddr_d  = bus.req_addr;
      pwdata_d = bus.req_write ? bus.req_wdata : '0;
      pstrb_d  = bus.req_write ? bus.req_strb : '0;
      pprot_d  = bus.req_prot;
    end
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !bus.PREADY && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (complete) begin
      rsp_err_d     = bus.PSLVERR;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
    end else if (timeout) begin
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d   = '0;
    end
  end

  always_comb begin
    bus.PSELX       = (state_q == SETUP) | (state_q == ACCESS);
    bus.PENABLE     = (state_q == ACCESS);
    bus.req_ready   = req_ready;
    bus.PWRITE      = pwrite_q;
    bus.PADDR       = paddr_q;
    bus.PWDATA      = pwdata_q;
    bus.PSTRB       = pstrb_q;
    bus.PPROT       = pprot_q;
    bus.rsp_valid   = rsp_valid_q;
    bus.rsp_err     = rsp_err_q;
    bus.rsp_timeout = rsp_timeout_q;
    bus.rsp_rdata   = rsp_rdata_q;
  end
endmodule
